// File: rtl/bus_datapath_p_if.sv
// Control/memory-facing signal bundle for the single-bus datapath.
// The master side (control unit plus memory model) drives micro-op fields and
// memory responses; the slave side (the datapath) returns memory requests,
// stall and architectural state.
interface bus_datapath_p_if #(
    parameter int DW   = 8,
    parameter int AW   = 16,
    parameter int NREG = 4
);
    logic [2:0]         src_sel;
    logic               drh_en;
    logic [2:0]         reg_src;
    logic [2:0]         reg_dst;
    logic [10:0]        ld_vec;
    logic               mem_wr_en;
    logic [3:0]         alus;
    logic [DW-1:0]      mem_rdata;
    logic               mem_ack;
    logic               mem_rd;
    logic               mem_wr;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic               stall;
    logic [DW-1:0]      ir_out;
    logic [NREG*DW-1:0] reg_out;
    logic               z_out;
    logic               c_out;
    logic [2:0]         err;

    modport master (
        output src_sel, drh_en, reg_src, reg_dst, ld_vec, mem_wr_en, alus,
               mem_rdata, mem_ack,
        input  mem_rd, mem_wr, mem_addr, mem_wdata, stall, ir_out, reg_out,
               z_out, c_out, err
    );

    modport slave (
        input  src_sel, drh_en, reg_src, reg_dst, ld_vec, mem_wr_en, alus,
               mem_rdata, mem_ack,
        output mem_rd, mem_wr, mem_addr, mem_wdata, stall, ir_out, reg_out,
               z_out, c_out, err
    );
endinterface

// File: rtl/bus_datapath_p.sv
// Parametrised single-bus datapath: PC, AR, DR, TR, IR, general registers,
// X/Y ALU staging and Z/C flags share one internal bus chosen by an encoded
// source select. Memory accesses use req/ack with stall and a timeout; faults
// are recorded in sticky error bits {tmo, contention, illegal}.
module bus_datapath_p #(
    parameter int DW      = 8,
    parameter int AW      = 16,
    parameter int NREG    = 4,
    parameter int MEM_TMO = 15
) (
    input  logic             clk,
    input  logic             rst,
    bus_datapath_p_if.slave  io
);
    // Stall counter only needs to reach MEM_TMO-1.
    localparam int CW = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO);
    localparam logic [3:0] NREG_L = 4'(NREG);

    generate
        if (AW != 2 * DW) begin : g_bad_aw
            $error("bus_datapath_p: AW must equal 2*DW");
        end
        if (NREG < 2 || NREG > 8) begin : g_bad_nreg
            $error("bus_datapath_p: NREG must be in 2..8");
        end
        if (MEM_TMO < 1) begin : g_bad_tmo
            $error("bus_datapath_p: MEM_TMO must be at least 1");
        end
    endgenerate

    // Architectural state
    logic [AW-1:0] pc_reg, ar_reg;
    logic [DW-1:0] dr_reg, tr_reg, ir_reg, x_reg, y_reg;
    logic          z_reg, c_reg;
    logic [DW-1:0] gpr_reg [NREG];
    logic [CW-1:0] stall_cnt_reg;
    logic [2:0]    err_reg;

    // Decoded load enables
    logic pc_ld, pc_inc, ar_ld, ar_inc, dr_ld, tr_ld, ir_ld, x_ld, y_ld, z_ld, reg_ld;
    assign {pc_ld, pc_inc, ar_ld, ar_inc, dr_ld, tr_ld, ir_ld, x_ld, y_ld, z_ld, reg_ld} = io.ld_vec;

    // Combinational intermediates
    logic          rd_op, wr_op, mem_wait, tmo_hit, stall_next, commit;
    logic          src_ok, dst_ok, illegal, contention;
    logic [DW-1:0] src_reg_val, bus_low;
    logic [AW-1:0] bus_val;
    logic [DW-1:0] bus_lo;
    logic [DW:0]   alu_wide;
    logic [DW-1:0] alu_res;
    logic          alu_c;

    // Memory handshake: a pending access stalls until ack or timeout; a
    // simultaneous read and write keeps the read and drops the write.
    always_comb begin
        rd_op      = !rst && (io.src_sel == 3'd5);
        wr_op      = !rst && io.mem_wr_en && (io.src_sel != 3'd5);
        mem_wait   = (rd_op || wr_op) && !io.mem_ack;
        tmo_hit    = mem_wait && (stall_cnt_reg == CW'(MEM_TMO - 1));
        stall_next = mem_wait && !tmo_hit;
        commit     = !stall_next;
    end

    // General-register source mux; an out-of-range index reads as zero.
    always_comb begin
        src_reg_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (io.reg_src == 3'(i)) src_reg_val = gpr_reg[i];
        end
    end

    // Fault classification for the sticky error bits.
    always_comb begin
        src_ok     = {1'b0, io.reg_src} < NREG_L;
        dst_ok     = {1'b0, io.reg_dst} < NREG_L;
        illegal    = (io.src_sel == 3'd7) ||
                     ((io.src_sel == 3'd6) && !src_ok) ||
                     (reg_ld && !dst_ok) ||
                     (io.mem_wr_en && (io.src_sel == 3'd5));
        contention = io.drh_en && (io.src_sel == 3'd1);
    end

    // Bus composition: PC owns the whole bus, otherwise the low half comes from
    // the selected source and the high half from DR when drh_en is set.
    always_comb begin
        bus_low = '0;
        case (io.src_sel)
            3'd2:    bus_low = dr_reg;
            3'd3:    bus_low = tr_reg;
            3'd4:    bus_low = y_reg;
            3'd5:    bus_low = io.mem_ack ? io.mem_rdata : '0;
            3'd6:    bus_low = src_reg_val;
            default: bus_low = '0;
        endcase
        if (io.src_sel == 3'd1) bus_val = pc_reg;
        else                    bus_val = {({DW{io.drh_en}} & dr_reg), bus_low};
        bus_lo = bus_val[DW-1:0];
    end

    // ALU on X and the low bus half; the extra MSB carries carry/borrow.
    always_comb begin
        alu_wide = '0;
        case (io.alus)
            4'd0:    alu_wide = {1'b0, x_reg} + {1'b0, bus_lo};
            4'd1:    alu_wide = {1'b0, x_reg} - {1'b0, bus_lo};
            4'd2:    alu_wide = {1'b0, x_reg & bus_lo};
            4'd3:    alu_wide = {1'b0, x_reg | bus_lo};
            4'd4:    alu_wide = {1'b0, x_reg ^ bus_lo};
            4'd5:    alu_wide = {1'b0, ~x_reg};
            4'd6:    alu_wide = {1'b0, bus_lo} + (DW+1)'(1);
            4'd8:    alu_wide = {1'b0, bus_lo};
            default: alu_wide = '0;
        endcase
        alu_res = alu_wide[DW-1:0];
        alu_c   = alu_wide[DW];
    end

    assign io.mem_rd    = rd_op;
    assign io.mem_wr    = wr_op;
    assign io.mem_addr  = ar_reg;
    assign io.mem_wdata = bus_lo;
    assign io.stall     = stall_next;
    assign io.ir_out    = ir_reg;
    assign io.z_out     = z_reg;
    assign io.c_out     = c_reg;
    assign io.err       = err_reg;

    // Dedicated registers and flags commit only when the micro-op completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= '0;
            ar_reg <= '0;
            dr_reg <= '0;
            tr_reg <= '0;
            ir_reg <= '0;
            x_reg  <= '0;
            y_reg  <= '0;
            z_reg  <= 1'b0;
            c_reg  <= 1'b0;
        end else if (commit) begin
            if (pc_ld)       pc_reg <= bus_val;
            else if (pc_inc) pc_reg <= pc_reg + AW'(1);
            if (ar_ld)       ar_reg <= bus_val;
            else if (ar_inc) ar_reg <= ar_reg + AW'(1);
            if (dr_ld) dr_reg <= bus_lo;
            if (tr_ld) tr_reg <= bus_lo;
            if (ir_ld) ir_reg <= bus_lo;
            if (x_ld)  x_reg  <= bus_lo;
            if (y_ld)  y_reg  <= alu_res;
            if (z_ld) begin
                z_reg <= (alu_res == '0);
                c_reg <= alu_c;
            end
        end
    end

    // Stall counter counts consecutive stalled cycles, clears on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             stall_cnt_reg <= '0;
        else if (stall_next) stall_cnt_reg <= stall_cnt_reg + CW'(1);
        else                 stall_cnt_reg <= '0;
    end

    // Sticky error bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_reg <= '0;
        else     err_reg <= err_reg | {tmo_hit, contention, illegal};
    end

    // General registers, one writer per entry; dst decode implies dst < NREG.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_gpr
            // Register gi captures the low bus half when addressed.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    gpr_reg[gi] <= '0;
                else if (commit && reg_ld && (io.reg_dst == 3'(gi)))
                    gpr_reg[gi] <= bus_lo;
            end
            assign io.reg_out[gi*DW +: DW] = gpr_reg[gi];
        end
    endgenerate
endmodule

// File: doc/bus_datapath_p.md
Name: bus_datapath_p

Overview:
- Parametrised successor to the tiny-CPU single-bus datapath: PC, AR, DR, TR, IR, NREG general registers, X/Y ALU staging, Z and C flags, all sharing one internal bus.
- The bus source is chosen by an encoded select, so drivers are exclusive by construction.
- Memory access uses a req/ack handshake with stall and timeout. Contention and protocol faults are logged in sticky error flags.
- Sits between the control unit (which issues one micro-op per cycle) and external memory.

Parameters:
- DW, 8, data width. Width of DR, TR, IR, X, Y and the general registers.
- AW, 16, address/bus width. Must equal 2*DW; elaboration fails otherwise.
- NREG, 4, number of general registers. Legal range 2..8.
- MEM_TMO, 15, maximum consecutive stall cycles before a memory timeout is declared. Must be ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- src_sel  in  3  bus source: 0 none, 1 PC, 2 DR, 3 TR, 4 Y, 5 MEM, 6 REG[reg_src], 7 reserved.
- drh_en  in  1  drive DR onto bus[AW-1:DW].
- reg_src  in  3  source register index.
- reg_dst  in  3  destination register index.
- ld_vec  in  11  load enables {pc_ld, pc_inc, ar_ld, ar_inc, dr_ld, tr_ld, ir_ld, x_ld, y_ld, z_ld, reg_ld}.
- mem_wr_en  in  1  write bus[DW-1:0] to memory at AR.
- alus  in  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT X, 6 INC bus, 7 CLR, 8 PASS bus; 9–15 give zero.
- mem_rdata  in  DW  memory read data.
- mem_ack  in  1  memory completion.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_addr  out  AW  = AR.
- mem_wdata  out  DW  = bus[DW-1:0].
- stall  out  1  micro-op not completed; control must hold all inputs stable.
- ir_out  out  DW  IR contents.
- reg_out  out  NREG*DW  all general registers, REG[i] at bits [i*DW +: DW].
- z_out  out  1  zero flag.
- c_out  out  1  carry/borrow flag.
- err  out  3  sticky {tmo, contention, illegal}.

Behaviour:
- Reset (async): every register, flag and err bit clears to 0. mem_rd, mem_wr and stall read 0 while rst=1.
- Bus composition (combinational):
  - low half: selected source, zero-extended to AW where narrower. PC drives the full AW.
  - high half: when drh_en=1, bus[AW-1:DW]=DR.
  - drh_en=1 with src_sel=PC: PC wins on the full bus and err[1] is set.
  - src_sel=7, reg_src≥NREG, or reg_dst≥NREG with reg_ld=1: bus/write treated as 0 / no write, and err[0] is set.
- Memory read: src_sel=5 drives mem_rd=1 combinationally.
  - mem_ack=1 in the same cycle: bus=mem_rdata, loads commit, stall=0.
  - mem_ack=0: stall=1 and all loads, incs and flag updates are suppressed.
- Memory write: mem_wr_en drives mem_wr=1, with the same ack/stall rule.
  - mem_wr_en together with src_sel=5: err[0] is set, no write occurs, and the read proceeds.
- Timeout: a stall counter increments each stalled cycle and clears on completion.
  - Reaching MEM_TMO stalled cycles: that cycle commits with read data=0 (writes are dropped), err[2] is set, stall drops.
- Load priority: pc_ld over pc_inc; ar_ld over ar_inc. Increments wrap modulo 2^AW.
- Register loads take bus[DW-1:0]; PC and AR take the full bus.
- ALU: combinational on X and bus[DW-1:0], result is DW bits.
  - ADD: C = carry-out.
  - SUB: X − bus, C = borrow.
  - INC: C = carry-out.
  - All other ops: C = 0.
  - z_ld=1 updates Z=(result==0) and C together.
  - y_ld captures the result.
- Same-edge read-after-write: a register that is both sourced and loaded in one cycle captures the bus value. The old value is driven.
- err bits are sticky until rst.

Test Plan:
- Reset mid-stall (src_sel=5, mem_ack=0, 3 cycles, assert rst): stall, mem_rd and all registers go to 0 immediately.
- PC=16'h00FF, pc_inc, src_sel=0: PC=16'h0100. Next cycle pc_ld+pc_inc with src_sel=1 and drh_en=0: PC unchanged (load of own value).
- DR=8'h12, TR=8'h34, src_sel=3, drh_en=1, pc_ld: PC=16'h1234, err=0.
- X=8'hFF, bus=REG[1]=8'h01, alus=ADD, z_ld, y_ld: Y=8'h00, Z=1, C=1. Then SUB with X=8'h00, bus=8'h01: Y=8'hFF, Z=0, C=1.
- AR=16'h0040, src_sel=5, dr_ld, mem_ack low for 2 cycles then high with 8'hA5: stall=1 for exactly 2 cycles, DR=8'hA5 after the third edge.
- mem_ack held low for MEM_TMO=15 cycles: DR=0 on the 15th edge, err=3'b100. drh_en with src_sel=1: err[1]=1.
